// File: rtl/wrr_arbiter_pkg.sv
// Shared FSM encodings for the weighted round-robin arbiter.
// The state values are plain defines so any file can use them without an import.
`ifndef WRR_ARBITER_DEFS
`define WRR_ARBITER_DEFS
`define WRR_ST_IDLE  1'b0
`define WRR_ST_BURST 1'b1
`endif

package wrr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = `WRR_ST_IDLE,
        ST_BURST = `WRR_ST_BURST
    } state_e;

    // Index width that stays legal when there is a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_priority_select.sv
// Wrapping priority search: the first set request at or above i_ptr,
// wrapping modulo N, reported as both a one-hot vector and an index.
module rr_priority_select #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [PTR_W-1:0] o_idx
);

    logic w_found;

    // Scan N positions starting at i_ptr; first hit wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(i_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            if (!w_found && i_req[j]) begin
                w_found     = 1'b1;
                o_onehot[j] = 1'b1;
                o_idx       = PTR_W'(j);
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one port owns the output for up to its
// weight in words, then ownership passes on after one idle cycle.
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int N_INPUTS     = 4,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_INPUTS-1:0]              valid_in,
    output logic [N_INPUTS-1:0]              ready_out,
    input  logic [N_INPUTS*DATA_WIDTH-1:0]   data_in,
    input  logic [N_INPUTS*WEIGHT_WIDTH-1:0] weight_in,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic [N_INPUTS-1:0]              grant
);

    localparam int PTR_W = ptr_width(N_INPUTS);
    localparam logic [WEIGHT_WIDTH-1:0] ONE_CNT = {{(WEIGHT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(N_INPUTS - 1);

    state_e                  r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_owner;
    logic [WEIGHT_WIDTH-1:0] r_cnt;
    logic [N_INPUTS-1:0]     r_grant;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;

    logic [N_INPUTS-1:0]     w_sel_onehot;
    logic [PTR_W-1:0]        w_sel_idx;
    logic [WEIGHT_WIDTH-1:0] w_sel_weight;
    logic [WEIGHT_WIDTH-1:0] w_sel_cnt;
    logic [DATA_WIDTH-1:0]   w_owner_data;
    logic [PTR_W-1:0]        w_next_ptr;
    logic                    w_owner_valid;
    logic                    w_out_free;
    logic                    w_fire;
    logic                    w_burst;

    rr_priority_select #(
        .N     (N_INPUTS),
        .PTR_W (PTR_W)
    ) u_select (
        .i_req    (valid_in),
        .i_ptr    (r_ptr),
        .o_onehot (w_sel_onehot),
        .o_idx    (w_sel_idx)
    );

    // Owner-side handshake and the weight latched at grant time.
    always_comb begin
        w_burst       = (r_state == ST_BURST);
        w_owner_valid = valid_in[r_owner];
        w_owner_data  = data_in[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
        w_sel_weight  = weight_in[int'(w_sel_idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        w_sel_cnt     = (w_sel_weight == '0) ? ONE_CNT : w_sel_weight;
        w_out_free    = !r_valid || ready_in;
        w_fire        = w_burst && w_owner_valid && w_out_free;
        w_next_ptr    = (r_owner == LAST_PORT) ? '0 : r_owner + PTR_W'(1);
        ready_out     = (w_burst && w_out_free) ? r_grant : '0;
    end

    // Arbitration FSM: grant, burst counting and pointer advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|valid_in) begin
                        r_state <= ST_BURST;
                        r_grant <= w_sel_onehot;
                        r_owner <= w_sel_idx;
                        r_cnt   <= w_sel_cnt;
                    end
                end
                ST_BURST: begin
                    if (w_fire) begin
                        r_cnt <= r_cnt - ONE_CNT;
                    end
                    // An owner that stops requesting forfeits the rest of its weight.
                    if ((w_fire && r_cnt == ONE_CNT) || !w_owner_valid) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_ptr   <= w_next_ptr;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Output register: load on transfer, drain when downstream accepts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_fire) begin
            r_data  <= w_owner_data;
            r_valid <= 1'b1;
        end else if (ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign grant     = r_grant;
    assign data_out  = r_data;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: cycle-by-cycle expected values, sampled
// on the falling edge, inputs changed on the falling edge.
module tb_wrr_arbiter;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    valid_in;
    logic [N-1:0]    ready_out;
    logic [N*DW-1:0] data_in;
    logic [N*WW-1:0] weight_in;
    logic [DW-1:0]   data_out;
    logic            valid_out;
    logic            ready_in;
    logic [N-1:0]    grant;

    int n_checks   = 0;
    int n_errors   = 0;
    int n_consumed = 0;
    int base;

    wrr_arbiter #(
        .DATA_WIDTH   (DW),
        .N_INPUTS     (N),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_in   (data_in),
        .weight_in (weight_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    // Count words taken by the downstream sink.
    always @(posedge clk) begin
        if (valid_out && ready_in) begin
            n_consumed <= n_consumed + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_data(input int p, input logic [DW-1:0] v);
        data_in[p*DW +: DW] = v;
    endtask

    task automatic set_weight(input int p, input logic [WW-1:0] v);
        weight_in[p*WW +: WW] = v;
    endtask

    task automatic do_reset();
        valid_in = 4'b0000;
        ready_in = 1'b1;
        rst      = 1'b0;
        #1;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_ready_out", 32'(ready_out), 32'h0);
        check_eq("rst_valid_out", 32'(valid_out), 32'h0);
        check_eq("rst_data_out", 32'(data_out), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        valid_in  = 4'b0000;
        ready_in  = 1'b1;
        data_in   = '0;
        weight_in = '0;
        #2;

        // Single port, weight 2: two words, idle cycle, new burst.
        do_reset();
        set_weight(0, 4'd2);
        set_data(0, 16'h00A0);
        valid_in = 4'b0001;
        tick();
        check_eq("t1_grant_a", 32'(grant), 32'h1);
        check_eq("t1_ready_a", 32'(ready_out), 32'h1);
        check_eq("t1_valid_a", 32'(valid_out), 32'h0);
        tick();
        check_eq("t1_data_a0", 32'(data_out), 32'hA0);
        check_eq("t1_valid_a0", 32'(valid_out), 32'h1);
        set_data(0, 16'h00A1);
        tick();
        check_eq("t1_data_a1", 32'(data_out), 32'hA1);
        check_eq("t1_idle_grant", 32'(grant), 32'h0);
        check_eq("t1_idle_ready", 32'(ready_out), 32'h0);
        set_data(0, 16'h00A2);
        tick();
        check_eq("t1_regrant", 32'(grant), 32'h1);
        check_eq("t1_bubble", 32'(valid_out), 32'h0);
        tick();
        check_eq("t1_data_a2", 32'(data_out), 32'hA2);
        check_eq("t1_valid_a2", 32'(valid_out), 32'h1);
        valid_in = 4'b0000;
        tick();
        check_eq("t1_drop_grant", 32'(grant), 32'h0);
        check_eq("t1_drop_valid", 32'(valid_out), 32'h0);

        // All ports, weight 1: grants 0,1,2,3,0 with an idle cycle between.
        do_reset();
        for (int p = 0; p < N; p++) begin
            set_weight(p, 4'd1);
            set_data(p, 16'(16'h00B0 + p));
        end
        valid_in = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check_eq("t2_grant", 32'(grant), 32'(4'b0001 << (g % 4)));
            check_eq("t2_valid_grant", 32'(valid_out), 32'h0);
            tick();
            check_eq("t2_gap", 32'(grant), 32'h0);
            check_eq("t2_data", 32'(data_out), 32'(16'h00B0 + (g % 4)));
        end
        valid_in = 4'b0000;
        tick();

        // Port 2 weight 3 with a 4-cycle downstream stall after the first word.
        do_reset();
        base = n_consumed;
        set_weight(2, 4'd3);
        set_data(2, 16'h00C0);
        valid_in = 4'b0100;
        tick();
        check_eq("t3_grant", 32'(grant), 32'h4);
        check_eq("t3_ready", 32'(ready_out), 32'h4);
        tick();
        check_eq("t3_data_c0", 32'(data_out), 32'hC0);
        ready_in = 1'b0;
        set_data(2, 16'h00C1);
        for (int s = 0; s < 4; s++) begin
            tick();
            check_eq("t3_stall_data", 32'(data_out), 32'hC0);
            check_eq("t3_stall_valid", 32'(valid_out), 32'h1);
            check_eq("t3_stall_ready", 32'(ready_out), 32'h0);
            check_eq("t3_stall_grant", 32'(grant), 32'h4);
        end
        ready_in = 1'b1;
        tick();
        check_eq("t3_data_c1", 32'(data_out), 32'hC1);
        check_eq("t3_grant_held", 32'(grant), 32'h4);
        set_data(2, 16'h00C2);
        tick();
        check_eq("t3_data_c2", 32'(data_out), 32'hC2);
        check_eq("t3_end_grant", 32'(grant), 32'h0);
        valid_in = 4'b0000;
        tick();
        check_eq("t3_words", 32'(n_consumed - base), 32'd3);

        // Port 1 weight 5 drops after 2 words; pointer moves to port 2.
        do_reset();
        set_weight(1, 4'd5);
        set_data(1, 16'h00D0);
        valid_in = 4'b0010;
        tick();
        check_eq("t4_grant", 32'(grant), 32'h2);
        tick();
        check_eq("t4_data_d0", 32'(data_out), 32'hD0);
        set_data(1, 16'h00D1);
        tick();
        check_eq("t4_data_d1", 32'(data_out), 32'hD1);
        check_eq("t4_still_owner", 32'(grant), 32'h2);
        set_weight(0, 4'd1);
        set_weight(2, 4'd1);
        set_data(0, 16'h00F0);
        set_data(2, 16'h00E0);
        valid_in = 4'b0101;
        tick();
        check_eq("t4_idle_grant", 32'(grant), 32'h0);
        check_eq("t4_idle_ready", 32'(ready_out), 32'h0);
        check_eq("t4_idle_valid", 32'(valid_out), 32'h0);
        tick();
        check_eq("t4_next_grant", 32'(grant), 32'h4);
        tick();
        check_eq("t4_data_e0", 32'(data_out), 32'hE0);
        valid_in = 4'b0000;
        tick();

        // Weight 0 on port 3 behaves as weight 1.
        do_reset();
        base = n_consumed;
        set_weight(3, 4'd0);
        set_data(3, 16'h0030);
        valid_in = 4'b1000;
        tick();
        check_eq("t5_grant_a", 32'(grant), 32'h8);
        tick();
        check_eq("t5_end_a", 32'(grant), 32'h0);
        check_eq("t5_data", 32'(data_out), 32'h30);
        tick();
        check_eq("t5_grant_b", 32'(grant), 32'h8);
        check_eq("t5_bubble", 32'(valid_out), 32'h0);
        tick();
        check_eq("t5_end_b", 32'(grant), 32'h0);
        valid_in = 4'b0000;
        tick();
        check_eq("t5_words", 32'(n_consumed - base), 32'd2);

        // Asynchronous reset mid-burst, then arbitration restarts at port 0.
        do_reset();
        set_weight(1, 4'd1);
        set_data(1, 16'h0061);
        valid_in = 4'b0010;
        tick();
        tick();
        check_eq("t6_first_end", 32'(grant), 32'h0);
        set_weight(2, 4'd4);
        set_data(2, 16'h0062);
        valid_in = 4'b0100;
        tick();
        check_eq("t6_grant2", 32'(grant), 32'h4);
        tick();
        check_eq("t6_valid_pre", 32'(valid_out), 32'h1);
        check_eq("t6_data_pre", 32'(data_out), 32'h62);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_async_valid", 32'(valid_out), 32'h0);
        check_eq("t6_async_grant", 32'(grant), 32'h0);
        check_eq("t6_async_ready", 32'(ready_out), 32'h0);
        check_eq("t6_async_data", 32'(data_out), 32'h0);
        set_weight(0, 4'd1);
        set_weight(3, 4'd1);
        valid_in = 4'b1001;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("t6_restart_grant", 32'(grant), 32'h1);
        valid_in = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of each requester data word.
REQ-002 Parameter N_INPUTS, default 4, number of requesters.
REQ-003 Parameter WEIGHT_WIDTH, default 4, width of each per-port burst weight.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 valid_in  input  N_INPUTS  per-requester data-valid, bit i = port i.
REQ-007 ready_out  output  N_INPUTS  per-requester accept; transfer on port i when valid_in[i] and ready_out[i] are both 1 at a clock edge.
REQ-008 data_in  input  N_INPUTS*DATA_WIDTH  flattened requester data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 weight_in  input  N_INPUTS*WEIGHT_WIDTH  flattened per-port max burst length, port i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-010 data_out  output  DATA_WIDTH  registered arbitrated data.
REQ-011 valid_out  output  1  data_out holds a word not yet consumed.
REQ-012 ready_in  input  1  downstream accept; word consumed when valid_out and ready_in are both 1.
REQ-013 grant  output  N_INPUTS  registered one-hot current owner, all-zero when no owner.

Function
REQ-014 FSM has exactly two states: IDLE (no owner) and BURST (one port owns the output).
REQ-015 IDLE: if any valid_in bit is set, the first set bit found searching upward from ptr, wrapping modulo N_INPUTS, becomes owner g; next cycle state=BURST, grant=onehot(g), cnt=weight_in[g].
REQ-016 Weight 0 is treated as 1; weight is sampled only at grant time, and changes mid-burst are ignored.
REQ-017 ready_out is all-zero in IDLE; in BURST, ready_out[g] = (!valid_out || ready_in), and all other bits are 0.
REQ-018 fire = BURST && valid_in[g] && ready_out[g]; on fire, data_out <= data_in[g], valid_out <= 1, cnt <= cnt-1.
REQ-019 Without fire, if ready_in is 1 then valid_out <= 0; otherwise valid_out and data_out hold.
REQ-020 Burst ends (state <= IDLE, grant <= 0, ptr <= (g+1) mod N_INPUTS) when fire occurs with cnt==1, or when valid_in[g] is 0 in BURST.
REQ-021 Latency: valid_in asserted in IDLE at edge k yields grant at k+1, first transfer at k+1 if the output register is free, and valid_out=1 at k+2.
REQ-022 One idle cycle (IDLE state) occurs between consecutive bursts; no data is lost or duplicated across the boundary.
REQ-023 Backpressure: with valid_out=1 and ready_in=0, data_out is stable and no port fires; cnt and the owner are held.
REQ-024 A port that drops valid_in mid-burst forfeits its remaining weight; round-robin fairness is guaranteed because ptr always advances past the last owner.
REQ-025 N_INPUTS=1 is legal: ptr stays 0, and the sole port is re-granted after each IDLE cycle.

Reset
REQ-026 While rst=0: state=IDLE, ptr=0, cnt=0, grant=0, ready_out=0, valid_out=0, data_out=0, immediately and independent of clk.
REQ-027 Reset asserted mid-burst discards the held output word and any partial burst; after release, arbitration restarts from port 0.

Structure
REQ-028 FSM state encodings (IDLE=0, BURST=1) are `define constants in a shared include file; no other shared types are needed.
REQ-029 The wrapping priority search is one combinational sub-module, rr_priority_select (inputs: request vector and ptr; outputs: one-hot and index).
REQ-030 State, ptr, cnt, grant and the output register are in wrr_arbiter; no other sub-modules.

Verification
REQ-031 Reset, then valid_in=4'b0001, weight0=2, ready_in=1, data 0xA0,0xA1,0xA2 -> out 0xA0,0xA1, one IDLE cycle, then 0xA2 in a new burst.
REQ-032 All ports valid, all weights 1, ready_in=1 -> grant sequence 0,1,2,3,0, each grant separated by one IDLE cycle.
REQ-033 Port 2 alone valid, weight 3; ready_in=0 for 4 cycles after first word -> data_out stable, ready_out=0, cnt held, and exactly 3 words delivered after release.
REQ-034 Port 1 owner with weight 5 drops valid_in after 2 words -> IDLE next cycle, ptr=2, and port 2 is granted next if requesting.
REQ-035 Weight 0 on port 3 with only port 3 requesting -> exactly one word per burst.
REQ-036 rst=0 pulse mid-burst with valid_out=1 -> valid_out and grant go to 0 without a clock edge; after release, the first grant goes to the lowest requesting index.
